reg_dump_reader: RTL and testbench

Debug-side reader for the register file's debug read port. On a start pulse it walks one or all 32 registers and drives `read_address_debug` and `clock_debug`. It captures each `data_out_debug` word and streams it out as four bytes, MSB first, over a valid/ready byte interface toward the board's UART/display logic. It sits beside the datapath and touches only the debug port, never the architectural read/write ports.

---
 rtl/reg_dump_pkg.sv | 23 ++
 rtl/reg_dump_reader_word_serializer.sv | 64 ++++++
 rtl/reg_dump_reader.sv | 104 ++++++++++
 tb/tb_reg_dump_reader.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_dump_pkg.sv
// Shared state encoding and default sizing for the register-file debug dump reader.
package reg_dump_pkg;

  localparam int DEFAULT_NUM_REGS = 32;
  localparam int DEFAULT_ADDR_W   = 5;
  localparam int DEFAULT_DATA_W   = 32;
  localparam int BYTES_PER_WORD   = DEFAULT_DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    PULSE,
    CAPTURE,
    SEND,
    DONE
  } dump_state_e;

  // Index counters need at least one bit even for a single-byte word.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_dump_reader_word_serializer.sv
// Holds one captured word and hands it out MSB byte first over a valid/ready byte stream.
module word_serializer
  import reg_dump_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int NUM_BYTES = BYTES_PER_WORD
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_i,
  input  logic [DATA_W-1:0] word_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              last_accept_o
);

  localparam int              IDX_W    = idx_width(NUM_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              valid_q, valid_d;
  logic              xfer;

  assign xfer = valid_q && tx_ready_i;

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (load_i) begin
      shift_d = word_i;
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (xfer) begin
      shift_d = shift_q << 8;
      if (idx_q == LAST_IDX) begin
        idx_d   = '0;
        valid_d = 1'b0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Reset is active-low; an in-flight word is simply dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign tx_data_o     = shift_q[DATA_W-1 -: 8];
  assign tx_valid_o    = valid_q;
  assign last_accept_o = xfer && (idx_q == LAST_IDX);

endmodule

// File: rtl/reg_dump_reader.sv
// Walks the register file debug port (one or all registers) and streams each word out as bytes.
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int DATA_W   = DEFAULT_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              dump_all,
  input  logic [ADDR_W-1:0] start_address,
  output logic [ADDR_W-1:0] read_address_debug,
  output logic              clock_debug,
  input  logic [DATA_W-1:0] data_out_debug,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              all_q, all_d;
  logic              clk_dbg_q, clk_dbg_d;
  logic              load_word;
  logic              last_accept;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      all_q     <= 1'b0;
      clk_dbg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      all_q     <= all_d;
      clk_dbg_q <= clk_dbg_d;
    end
  end

  // The address is set up a full cycle before the debug clock rises, and the
  // data gets a further full cycle to settle before it is captured.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    all_d     = all_q;
    load_word = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ADDR;
          all_d   = dump_all;
          addr_d  = dump_all ? '0 : start_address;
        end
      end
      ADDR:    state_d = PULSE;
      PULSE:   state_d = CAPTURE;
      CAPTURE: begin
        state_d   = SEND;
        load_word = 1'b1;
      end
      SEND: begin
        if (last_accept) begin
          if (!all_q || addr_q == LAST_ADDR) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = ADDR;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign clk_dbg_d = (state_d == PULSE);

  word_serializer #(
    .DATA_W   (DATA_W),
    .NUM_BYTES(DATA_W / 8)
  ) u_serializer (
    .clock        (clock),
    .reset        (reset),
    .load_i       (load_word),
    .word_i       (data_out_debug),
    .tx_data_o    (tx_data),
    .tx_valid_o   (tx_valid),
    .tx_ready_i   (tx_ready),
    .last_accept_o(last_accept)
  );

  assign read_address_debug = addr_q;
  assign clock_debug        = clk_dbg_q;
  assign busy               = (state_q != IDLE);
  assign done               = (state_q == DONE);

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader with a behavioural register file on the debug port.
module tb_reg_dump_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        dump_all = 1'b0;
  logic [4:0]  start_address = '0;
  logic [4:0]  read_address_debug;
  logic        clock_debug;
  logic [31:0] data_out_debug = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic        done;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] regFile [0:31];
  logic [7:0]  byteQ[$];
  logic [4:0]  pulseAddrQ[$];
  int          pulseCount = 0;
  int          widePulses = 0;
  int          pulseRun = 0;

  reg_dump_reader dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .dump_all          (dump_all),
    .start_address     (start_address),
    .read_address_debug(read_address_debug),
    .clock_debug       (clock_debug),
    .data_out_debug    (data_out_debug),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .busy              (busy),
    .done              (done)
  );

  always #5 clock = ~clock;

  // Register file debug read port: data follows the address on the debug clock edge.
  always @(posedge clock_debug) data_out_debug <= regFile[read_address_debug];

  // Inputs change on the falling edge; the monitor looks 1 time unit later.
  always @(negedge clock) begin
    #1;
    if (tx_valid === 1'b1 && tx_ready === 1'b1) byteQ.push_back(tx_data);
    if (clock_debug === 1'b1) begin
      if (pulseRun == 0) begin
        pulseCount++;
        pulseAddrQ.push_back(read_address_debug);
      end
      pulseRun++;
      if (pulseRun == 2) widePulses++;
    end else begin
      pulseRun = 0;
    end
  end

  task automatic clearMonitor();
    byteQ.delete();
    pulseAddrQ.delete();
    pulseCount = 0;
    widePulses = 0;
    pulseRun = 0;
  endtask

  task automatic startDump(input logic dumpAll, input logic [4:0] addr);
    @(negedge clock);
    start = 1'b1;
    dump_all = dumpAll;
    start_address = addr;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic runDump(input logic dumpAll, input logic [4:0] addr, input int budget,
                         output int doneCycle, output logic busyFirst);
    int n;
    startDump(dumpAll, addr);
    doneCycle = -1;
    n = 1;
    #1;
    busyFirst = busy;
    while (n <= budget) begin
      if (done === 1'b1) begin
        doneCycle = n;
        break;
      end
      @(negedge clock);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    compared++; if (read_address_debug !== 5'd0) begin mismatched++; $display("[TB] FAIL reset_addr: observed %h, expected 00", read_address_debug); end
    compared++; if (clock_debug !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_clock_debug: observed %b, expected 0", clock_debug); end
    compared++; if (tx_data !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_tx_data: observed %h, expected 00", tx_data); end
    compared++; if (tx_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_tx_valid: observed %b, expected 0", tx_valid); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: observed %b, expected 0", busy); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: observed %b, expected 0", done); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_full_dump();
    int dc;
    logic bf;
    logic [7:0] expByte;
    clearMonitor();
    tx_ready = 1'b1;
    runDump(1'b1, 5'd0, 400, dc, bf);
    compared++; if (bf !== 1'b1) begin mismatched++; $display("[TB] FAIL full_busy_rise: observed %b, expected 1", bf); end
    compared++; if (dc != 225) begin mismatched++; $display("[TB] FAIL full_done_cycle: observed %0d, expected 225", dc); end
    compared++; if (byteQ.size() != 128) begin mismatched++; $display("[TB] FAIL full_byte_count: observed %0d, expected 128", byteQ.size()); end
    compared++; if (pulseCount != 32) begin mismatched++; $display("[TB] FAIL full_pulse_count: observed %0d, expected 32", pulseCount); end
    compared++; if (widePulses != 0) begin mismatched++; $display("[TB] FAIL full_pulse_width: observed %0d wide pulses, expected 0", widePulses); end
    for (int i = 0; i < byteQ.size() && i < 128; i++) begin
      expByte = (i % 4 == 3) ? 8'(i / 4) : 8'h00;
      compared++;
      if (byteQ[i] !== expByte) begin
        mismatched++;
        $display("[TB] FAIL full_byte[%0d]: observed %h, expected %h", i, byteQ[i], expByte);
      end
    end
  endtask

  task automatic test_single();
    int dc;
    logic bf;
    logic [7:0] expBytes [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    regFile[5] = 32'hDEADBEEF;
    clearMonitor();
    tx_ready = 1'b1;
    runDump(1'b0, 5'd5, 50, dc, bf);
    compared++; if (dc != 8) begin mismatched++; $display("[TB] FAIL single_done_cycle: observed %0d, expected 8", dc); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL single_busy_with_done: observed %b, expected 1", busy); end
    compared++; if (byteQ.size() != 4) begin mismatched++; $display("[TB] FAIL single_byte_count: observed %0d, expected 4", byteQ.size()); end
    for (int i = 0; i < byteQ.size() && i < 4; i++) begin
      compared++;
      if (byteQ[i] !== expBytes[i]) begin mismatched++; $display("[TB] FAIL single_byte[%0d]: observed %h, expected %h", i, byteQ[i], expBytes[i]); end
    end
    compared++; if (pulseCount != 1) begin mismatched++; $display("[TB] FAIL single_pulse_count: observed %0d, expected 1", pulseCount); end
    compared++;
    if (((pulseAddrQ.size() > 0) ? pulseAddrQ[0] : 5'h1f) !== 5'd5) begin
      mismatched++;
      $display("[TB] FAIL single_pulse_addr: observed %h, expected 05", (pulseAddrQ.size() > 0) ? pulseAddrQ[0] : 5'h1f);
    end
    @(negedge clock);
    #1;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL single_busy_fall: observed %b, expected 0", busy); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL single_done_width: observed %b, expected 0", done); end
  endtask

  task automatic test_backpressure();
    int n;
    int dc;
    logic stalled;
    logic [7:0] expBytes [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    clearMonitor();
    tx_ready = 1'b1;
    startDump(1'b0, 5'd5);
    n = 1;
    dc = -1;
    stalled = 1'b0;
    while (n <= 60 && dc < 0) begin
      #1;
      if (done === 1'b1) begin
        dc = n;
      end else if (!stalled && tx_valid === 1'b1 && tx_data === 8'hDE) begin
        stalled = 1'b1;
        @(negedge clock);
        n++;
        tx_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
          #1;
          compared++; if (tx_data !== 8'hAD) begin mismatched++; $display("[TB] FAIL stall_data[%0d]: observed %h, expected ad", k, tx_data); end
          compared++; if (tx_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL stall_valid[%0d]: observed %b, expected 1", k, tx_valid); end
          @(negedge clock);
          n++;
        end
        tx_ready = 1'b1;
      end else begin
        @(negedge clock);
        n++;
      end
    end
    tx_ready = 1'b1;
    compared++; if (stalled !== 1'b1) begin mismatched++; $display("[TB] FAIL stall_reached: observed %b, expected 1", stalled); end
    compared++; if (dc != 18) begin mismatched++; $display("[TB] FAIL stall_done_cycle: observed %0d, expected 18", dc); end
    compared++; if (byteQ.size() != 4) begin mismatched++; $display("[TB] FAIL stall_byte_count: observed %0d, expected 4", byteQ.size()); end
    for (int i = 0; i < byteQ.size() && i < 4; i++) begin
      compared++;
      if (byteQ[i] !== expBytes[i]) begin mismatched++; $display("[TB] FAIL stall_byte[%0d]: observed %h, expected %h", i, byteQ[i], expBytes[i]); end
    end
  endtask

  task automatic test_start_while_busy();
    int doneCycles[$];
    logic [7:0] expBytes [8] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h03};
    clearMonitor();
    tx_ready = 1'b1;
    startDump(1'b0, 5'd5);
    // Cycle 5 is SEND and cycle 8 is DONE of the first dump; cycle 9 is IDLE again.
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) @(negedge clock);
      start = (n == 5) || (n == 8) || (n == 9);
      dump_all = (n == 9) ? 1'b0 : 1'b1;
      start_address = (n == 9) ? 5'd3 : 5'd7;
      #1;
      if (done === 1'b1) doneCycles.push_back(n);
    end
    compared++; if (doneCycles.size() != 2) begin mismatched++; $display("[TB] FAIL busy_done_count: observed %0d, expected 2", doneCycles.size()); end
    compared++;
    if (((doneCycles.size() > 0) ? doneCycles[0] : -1) != 8) begin
      mismatched++;
      $display("[TB] FAIL busy_first_done: observed %0d, expected 8", (doneCycles.size() > 0) ? doneCycles[0] : -1);
    end
    compared++;
    if (((doneCycles.size() > 1) ? doneCycles[1] : -1) != 17) begin
      mismatched++;
      $display("[TB] FAIL busy_second_done: observed %0d, expected 17", (doneCycles.size() > 1) ? doneCycles[1] : -1);
    end
    compared++; if (byteQ.size() != 8) begin mismatched++; $display("[TB] FAIL busy_byte_count: observed %0d, expected 8", byteQ.size()); end
    for (int i = 0; i < byteQ.size() && i < 8; i++) begin
      compared++;
      if (byteQ[i] !== expBytes[i]) begin mismatched++; $display("[TB] FAIL busy_byte[%0d]: observed %h, expected %h", i, byteQ[i], expBytes[i]); end
    end
    compared++; if (pulseCount != 2) begin mismatched++; $display("[TB] FAIL busy_pulse_count: observed %0d, expected 2", pulseCount); end
  endtask

  task automatic test_reset_mid_dump();
    int dc;
    logic bf;
    logic found;
    logic [7:0] expWord12 [4] = '{8'h00, 8'h00, 8'h00, 8'h0C};
    clearMonitor();
    tx_ready = 1'b1;
    startDump(1'b1, 5'd0);
    found = 1'b0;
    for (int n = 1; n <= 300 && !found; n++) begin
      #1;
      if (tx_valid === 1'b1 && read_address_debug === 5'd12) found = 1'b1;
      else @(negedge clock);
    end
    compared++; if (found !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_reach_reg12: observed %b, expected 1", found); end
    #1;
    reset = 1'b0;
    #1;
    compared++; if (read_address_debug !== 5'd0) begin mismatched++; $display("[TB] FAIL mid_reset_addr: observed %h, expected 00", read_address_debug); end
    compared++; if (clock_debug !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_reset_clock_debug: observed %b, expected 0", clock_debug); end
    compared++; if (tx_data !== 8'h00) begin mismatched++; $display("[TB] FAIL mid_reset_tx_data: observed %h, expected 00", tx_data); end
    compared++; if (tx_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_reset_tx_valid: observed %b, expected 0", tx_valid); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_reset_busy: observed %b, expected 0", busy); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_reset_done: observed %b, expected 0", done); end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    clearMonitor();
    runDump(1'b1, 5'd0, 400, dc, bf);
    compared++; if (dc != 225) begin mismatched++; $display("[TB] FAIL mid_redump_done_cycle: observed %0d, expected 225", dc); end
    compared++; if (byteQ.size() != 128) begin mismatched++; $display("[TB] FAIL mid_redump_byte_count: observed %0d, expected 128", byteQ.size()); end
    compared++;
    if (((pulseAddrQ.size() > 0) ? pulseAddrQ[0] : 5'h1f) !== 5'd0) begin
      mismatched++;
      $display("[TB] FAIL mid_redump_first_addr: observed %h, expected 00", (pulseAddrQ.size() > 0) ? pulseAddrQ[0] : 5'h1f);
    end
    for (int i = 0; i < 4 && 48 + i < byteQ.size(); i++) begin
      compared++;
      if (byteQ[48 + i] !== expWord12[i]) begin mismatched++; $display("[TB] FAIL mid_redump_reg12_byte[%0d]: observed %h, expected %h", i, byteQ[48 + i], expWord12[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regFile[i] = 32'(i);
    $display("[TB] starting reg_dump_reader bench");
    test_reset();
    test_full_dump();
    test_single();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_dump();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
